// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the 2:1 round-robin stream merger.
package stream_mux_pkg;

    localparam int unsigned SRC_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester combinational arbiter: fixed grant while held, else sole requester or prio on a tie.
module rr_arb2
    import stream_mux_pkg::*;
(
    input  logic [1:0]       req_i,
    input  logic [SRC_W-1:0] prio_i,
    input  logic             hold_i,
    input  logic [SRC_W-1:0] hold_id_i,
    output logic [SRC_W-1:0] gnt_id_o,
    output logic             gnt_vld_o
);

    always_comb begin
        gnt_id_o  = prio_i;
        gnt_vld_o = 1'b0;
        if (hold_i) begin
            // A held grant stays valid even if its source drops valid mid-packet.
            gnt_id_o  = hold_id_i;
            gnt_vld_o = 1'b1;
        end else begin
            unique case (req_i)
                2'b01: begin
                    gnt_id_o  = 1'b0;
                    gnt_vld_o = 1'b1;
                end
                2'b10: begin
                    gnt_id_o  = 1'b1;
                    gnt_vld_o = 1'b1;
                end
                2'b11: begin
                    gnt_id_o  = prio_i;
                    gnt_vld_o = 1'b1;
                end
                default: begin
                    gnt_id_o  = prio_i;
                    gnt_vld_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stream_mux_2x1_rr.sv
// Merges two valid/ready streams into one registered output with round-robin, packet-atomic arbitration.
module stream_mux_2x1_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter bit          PKT_MODE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_valid,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_valid,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic [SRC_W-1:0]  m_src,
    input  logic              m_ready
);

    state_t              state_q;
    logic [SRC_W-1:0]    prio_q;
    logic [DATA_W-1:0]   m_data_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic [SRC_W-1:0]    m_src_q;

    logic                adv;
    logic                hold;
    logic [SRC_W-1:0]    hold_id;
    logic [SRC_W-1:0]    gnt_id;
    logic                gnt_vld;
    logic                acc;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;

    assign adv     = ~m_valid_q | m_ready;
    assign hold    = (state_q != ST_IDLE);
    assign hold_id = (state_q == ST_LOCK1);

    rr_arb2 u_arb (
        .req_i     ({s1_valid, s0_valid}),
        .prio_i    (prio_q),
        .hold_i    (hold),
        .hold_id_i (hold_id),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    assign s0_ready = ~rst & adv & gnt_vld & (gnt_id == 1'b0);
    assign s1_ready = ~rst & adv & gnt_vld & (gnt_id == 1'b1);

    assign acc      = (s0_ready & s0_valid) | (s1_ready & s1_valid);
    assign sel_data = (gnt_id == 1'b1) ? s1_data : s0_data;
    assign sel_last = (gnt_id == 1'b1) ? s1_last : s0_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prio_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_src_q   <= '0;
        end else if (adv) begin
            m_valid_q <= acc;
            if (acc) begin
                m_data_q <= sel_data;
                m_last_q <= sel_last;
                m_src_q  <= gnt_id;
                if (!PKT_MODE || sel_last) begin
                    prio_q <= ~gnt_id;
                end
                if (PKT_MODE) begin
                    if (sel_last) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= (gnt_id == 1'b1) ? ST_LOCK1 : ST_LOCK0;
                    end
                end
            end
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_src   = m_src_q;

endmodule

// File: tb/tb_stream_mux_2x1_rr.sv
// Directed bench: per-cycle vector table for the packet-mode merger plus a beat-mode alternation sequence.
module tb_stream_mux_2x1_rr;

    typedef struct {
        logic       r;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       mr;
        logic       er0;
        logic       er1;
        logic       emv;
        logic [7:0] emd;
        logic       eml;
        logic       ems;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s0_data, s1_data;
    logic       s0_valid, s0_last, s1_valid, s1_last, m_ready;

    logic       p_s0_ready, p_s1_ready, p_m_valid, p_m_last;
    logic [7:0] p_m_data;
    logic [0:0] p_m_src;
    logic       b_s0_ready, b_s1_ready, b_m_valid, b_m_last;
    logic [7:0] b_m_data;
    logic [0:0] b_m_src;

    int unsigned total = 0;
    int unsigned bad   = 0;

    vec_t tbl [25];

    always #5 clk = ~clk;

    stream_mux_2x1_rr #(.DATA_W(8), .PKT_MODE(1'b1)) u_pkt (
        .clk(clk), .rst(rst),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(p_s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(p_s1_ready),
        .m_data(p_m_data), .m_valid(p_m_valid), .m_last(p_m_last), .m_src(p_m_src),
        .m_ready(m_ready)
    );

    stream_mux_2x1_rr #(.DATA_W(8), .PKT_MODE(1'b0)) u_beat (
        .clk(clk), .rst(rst),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(b_s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(b_s1_ready),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_last(b_m_last), .m_src(b_m_src),
        .m_ready(m_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v0, input logic [7:0] d0, input logic l0,
                                input logic v1, input logic [7:0] d1, input logic l1, input logic mr,
                                input logic er0, input logic er1, input logic emv,
                                input logic [7:0] emd, input logic eml, input logic ems);
        vec_t v;
        v.r = r;   v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.mr = mr;
        v.er0 = er0; v.er1 = er1; v.emv = emv; v.emd = emd; v.eml = eml; v.ems = ems;
        return v;
    endfunction

    initial begin
        // r  v0 d0     l0 v1 d1     l1 mr | er0 er1 emv emd   eml ems
        tbl[0]  = mk(1, 1, 8'h11, 0, 1, 8'h22, 0, 1,  0, 0, 0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 1, 8'h11, 0, 1, 8'h22, 0, 1,  0, 0, 0, 8'h00, 0, 0);
        tbl[2]  = mk(0, 1, 8'hA0, 0, 1, 8'hB0, 1, 1,  1, 0, 1, 8'hA0, 0, 0);
        tbl[3]  = mk(0, 1, 8'hA1, 0, 1, 8'hB0, 1, 1,  1, 0, 1, 8'hA1, 0, 0);
        tbl[4]  = mk(0, 1, 8'hA2, 1, 1, 8'hB0, 1, 1,  1, 0, 1, 8'hA2, 1, 0);
        tbl[5]  = mk(0, 0, 8'h00, 0, 1, 8'hB0, 1, 1,  0, 1, 1, 8'hB0, 1, 1);
        tbl[6]  = mk(0, 1, 8'hC0, 1, 1, 8'hD0, 1, 0,  0, 0, 1, 8'hB0, 1, 1);
        tbl[7]  = mk(0, 1, 8'hC0, 1, 1, 8'hD0, 1, 0,  0, 0, 1, 8'hB0, 1, 1);
        tbl[8]  = mk(0, 1, 8'hC0, 1, 1, 8'hD0, 1, 0,  0, 0, 1, 8'hB0, 1, 1);
        tbl[9]  = mk(0, 1, 8'hC0, 1, 1, 8'hD0, 1, 0,  0, 0, 1, 8'hB0, 1, 1);
        tbl[10] = mk(0, 1, 8'hC0, 1, 1, 8'hD0, 1, 1,  1, 0, 1, 8'hC0, 1, 0);
        tbl[11] = mk(0, 0, 8'h00, 0, 1, 8'hE0, 0, 1,  0, 1, 1, 8'hE0, 0, 1);
        tbl[12] = mk(0, 1, 8'hC1, 1, 1, 8'hE1, 0, 1,  0, 1, 1, 8'hE1, 0, 1);
        tbl[13] = mk(1, 1, 8'hC1, 1, 1, 8'hE2, 0, 1,  0, 0, 0, 8'h00, 0, 0);
        tbl[14] = mk(0, 1, 8'hC1, 1, 1, 8'hE2, 0, 1,  1, 0, 1, 8'hC1, 1, 0);
        tbl[15] = mk(0, 1, 8'hC2, 1, 1, 8'hE2, 0, 1,  0, 1, 1, 8'hE2, 0, 1);
        tbl[16] = mk(0, 1, 8'hC2, 1, 0, 8'h00, 0, 1,  0, 1, 0, 8'h00, 0, 0);
        tbl[17] = mk(0, 1, 8'hC2, 1, 1, 8'hE3, 1, 1,  0, 1, 1, 8'hE3, 1, 1);
        tbl[18] = mk(0, 1, 8'hF0, 1, 1, 8'h90, 1, 1,  1, 0, 1, 8'hF0, 1, 0);
        tbl[19] = mk(0, 1, 8'hF1, 1, 1, 8'h90, 1, 1,  0, 1, 1, 8'h90, 1, 1);
        tbl[20] = mk(0, 1, 8'hF1, 1, 1, 8'h91, 1, 1,  1, 0, 1, 8'hF1, 1, 0);
        tbl[21] = mk(0, 1, 8'hF2, 1, 1, 8'h91, 1, 1,  0, 1, 1, 8'h91, 1, 1);
        tbl[22] = mk(0, 1, 8'hF2, 1, 1, 8'h92, 1, 1,  1, 0, 1, 8'hF2, 1, 0);
        tbl[23] = mk(0, 1, 8'hF3, 1, 1, 8'h92, 1, 1,  0, 1, 1, 8'h92, 1, 1);
        tbl[24] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0);

        rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
        s0_data = '0; s1_data = '0; s0_last = 1'b0; s1_last = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 25; i++) begin
            rst = tbl[i].r; m_ready = tbl[i].mr;
            s0_valid = tbl[i].v0; s0_data = tbl[i].d0; s0_last = tbl[i].l0;
            s1_valid = tbl[i].v1; s1_data = tbl[i].d1; s1_last = tbl[i].l1;
            #2;
            chk($sformatf("v%0d s0_ready", i), 32'(p_s0_ready), 32'(tbl[i].er0));
            chk($sformatf("v%0d s1_ready", i), 32'(p_s1_ready), 32'(tbl[i].er1));
            @(posedge clk); #1;
            chk($sformatf("v%0d m_valid", i), 32'(p_m_valid), 32'(tbl[i].emv));
            if (tbl[i].emv || tbl[i].r) begin
                chk($sformatf("v%0d m_data", i), 32'(p_m_data), 32'(tbl[i].emd));
                chk($sformatf("v%0d m_last", i), 32'(p_m_last), 32'(tbl[i].eml));
                chk($sformatf("v%0d m_src", i), 32'(p_m_src), 32'(tbl[i].ems));
            end
        end

        // Beat-mode instance: both sources always valid, expect strict alternation with no bubbles.
        rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("beat reset m_valid", 32'(b_m_valid), 32'd0);
        rst = 1'b0;
        for (int unsigned k = 0; k < 6; k++) begin
            s0_valid = 1'b1; s0_last = 1'b0; s0_data = 8'hA0 + 8'((k + 1) / 2);
            s1_valid = 1'b1; s1_last = 1'b0; s1_data = 8'hB0 + 8'(k / 2);
            #2;
            chk($sformatf("beat%0d s0_ready", k), 32'(b_s0_ready), 32'((k % 2) == 0));
            chk($sformatf("beat%0d s1_ready", k), 32'(b_s1_ready), 32'((k % 2) == 1));
            @(posedge clk); #1;
            chk($sformatf("beat%0d m_valid", k), 32'(b_m_valid), 32'd1);
            chk($sformatf("beat%0d m_src", k), 32'(b_m_src), 32'(k % 2));
            chk($sformatf("beat%0d m_data", k), 32'(b_m_data),
                ((k % 2) == 0) ? 32'(8'hA0 + 8'(k / 2)) : 32'(8'hB0 + 8'(k / 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
